sdram_port_arbiter: RTL
=======================

# sdram_port_arbiter

Two-client front end for the SDRAM controller, clocked on the 50 MHz system clock. Round-robin arbitration picks one client request at a time. The block latches the request's address and write data and issues a single-cycle read or write request pulse to the controller. It then waits for the controller's completion strobe (rising edge of `data_valid` or `write_complete`) and returns read data plus a one-cycle ack to the granted client. It also holds off all traffic until the controller's power-up init window has elapsed, and aborts hung transactions with an error ack.

## Interface
Parameters:
- `INIT_CYCLES`, 16384: clock cycles after reset before the first request is accepted.
- `TIMEOUT_CYCLES`, 255: maximum number of cycles spent in WAIT before an abort; 8-bit counter.

Ports:
- `CLOCK_50`  in  1  system clock; every register is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `c0_req`, `c1_req`  in  1  client request; held high until that client's ack.
- `c0_we`, `c1_we`  in  1  1 = write, 0 = read; sampled at grant.
- `c0_addr`, `c1_addr`  in  24  word address; sampled at grant.
- `c0_wdata`, `c1_wdata`  in  32  write data; sampled at grant.
- `c0_ack`, `c1_ack`  out  1  one-cycle completion pulse.
- `c0_err`, `c1_err`  out  1  high only together with ack; 1 = timed out.
- `rdata`  out  32  read data; valid in the ack cycle, held until the next read completes.
- `ready`  out  1  init window has elapsed.
- `mem_address`  out  24  drives controller `address`.
- `mem_data_in`  out  32  drives controller `data_in`.
- `mem_req_read`, `mem_req_write`  out  1  one-cycle request pulses.
- `mem_data_out`  in  32  controller read data.
- `mem_data_valid`, `mem_write_complete`  in  1  controller completion levels.

## Operation
- Reset values: all outputs 0, `rdata` 0, state INIT, init counter `INIT_CYCLES`-1, timeout counter 0, `last_grant` 1 (so client 0 wins the first tie).
- Registers `dv_q` and `wc_q` hold the previous cycle's `mem_data_valid` and `mem_write_complete`. Completion means `mem_data_valid & ~dv_q` for a read, or `mem_write_complete & ~wc_q` for a write.
  - A level held for more than one cycle counts once.
  - A completion edge outside WAIT is ignored.
- States:
  - **INIT**: decrement the init counter. At 0, set `ready` = 1 and go to IDLE. `ready` stays 1 until the next reset.
  - **IDLE**: with exactly one request, grant it. With both requesting, grant `~last_grant`. On a grant, latch `mem_address`, `mem_data_in` and the we-flag, set `last_grant`, and go to ISSUE.
  - **ISSUE**: pulse `mem_req_write` if the latched we-flag is 1, otherwise pulse `mem_req_read`, for exactly one cycle. Clear the timeout counter. Go to WAIT.
  - **WAIT**: increment the timeout counter.
    - On the completion edge that matches the we-flag, capture `mem_data_out` into `rdata` (reads only) and go to RESP with err = 0.
    - If the counter reaches `TIMEOUT_CYCLES` with no edge, go to RESP with err = 1 and leave `rdata` unchanged.
    - A completion edge wins over a timeout that happens in the same cycle.
  - **RESP**: assert ack (and err) on the granted client for one cycle, then go to IDLE. Requests are not sampled in RESP.
- A `req` still high in the cycle after ack is treated as a new request. The minimum gap between a client's back-to-back grants is 1 IDLE cycle.
- `mem_address` and `mem_data_in` stay stable from ISSUE until the next grant.
- `mem_req_read` and `mem_req_write` are never high together, and never high outside ISSUE.
- Reset in mid-transaction: all state clears immediately, no ack is issued, and INIT restarts.

## Timing
- Grant latency: a `req` that is high in IDLE in cycle N gives ISSUE (request pulse) in cycle N+1 and WAIT from N+2.
- Ack comes 1 cycle after the completion edge is detected.
- Total latency: request to ack = 3 cycles + controller completion time.
- With both clients requesting continuously, grants alternate 0, 1, 0, 1, and each client waits at most one foreign transaction.

## Test plan
- Reset with `INIT_CYCLES` = 8, `c0_req` held high from cycle 0 -> `ready` rises at cycle 8, no `mem_req_*` before then, then `mem_req_read` pulses once.
- Client 0 writes 0xDEADBEEF to 0x000123, then reads 0x000123 back through the controller model -> one `mem_req_write` pulse, then one `mem_req_read` pulse; `c0_ack` for each with err = 0; `rdata` = 0xDEADBEEF.
- `c0_req` and `c1_req` both held high for 4 transactions -> grant order 0, 1, 0, 1; each ack pulses exactly one cycle.
- `mem_data_valid` held high for 3 cycles -> exactly one `c1_ack`; a second assertion of `mem_data_valid` while in IDLE -> no ack.
- Model never completes, `TIMEOUT_CYCLES` = 20 -> `c0_ack` = 1 and `c0_err` = 1 exactly 20 cycles after WAIT is entered, `rdata` unchanged, next grant proceeds normally.
- Assert `rst_n` low during WAIT -> all outputs 0 asynchronously; after release, `ready` = 0 for the full `INIT_CYCLES` and no stale ack appears.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Two-client round-robin front end for the SDRAM controller. Accepts one
//   client request at a time, latches its address/data, pulses a single-cycle
//   read or write request to the controller, waits for the controller's
//   completion edge and returns a one-cycle ack (with err on timeout) to the
//   granted client. All traffic is held off until the controller's power-up
//   init window has elapsed.
//
// Ports
//   CLOCK_50, rst_n          system clock, async active-low reset
//   c0_*/c1_*                client request/we/addr/wdata in, ack/err out
//   rdata                    read data of the last completed read
//   ready                    init window elapsed (sticky until reset)
//   mem_address/mem_data_in  latched address / write data to the controller
//   mem_req_read/write       one-cycle request pulses to the controller
//   mem_data_out             controller read data
//   mem_data_valid           controller read completion level
//   mem_write_complete       controller write completion level
module sdram_port_arbiter #(
  parameter int INIT_CYCLES    = 16384,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        c0_req,
  input  logic        c1_req,
  input  logic        c0_we,
  input  logic        c1_we,
  input  logic [23:0] c0_addr,
  input  logic [23:0] c1_addr,
  input  logic [31:0] c0_wdata,
  input  logic [31:0] c1_wdata,
  output logic        c0_ack,
  output logic        c1_ack,
  output logic        c0_err,
  output logic        c1_err,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [23:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_req_read,
  output logic        mem_req_write,
  input  logic [31:0] mem_data_out,
  input  logic        mem_data_valid,
  input  logic        mem_write_complete
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state, state_n;
  logic [INIT_W-1:0] init_cnt;
  logic [7:0]        tcnt;
  logic              last_grant;   // doubles as the currently granted client
  logic              we_q;
  logic              err_q;
  logic              dv_q;
  logic              wc_q;

  logic              grant_en;
  logic              grant_sel;
  logic              done_edge;
  logic              finish_ok;
  logic              finish_to;

  always_comb begin
    state_n   = state;
    grant_en  = 1'b0;
    grant_sel = last_grant;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    done_edge = we_q ? (mem_write_complete & ~wc_q) : (mem_data_valid & ~dv_q);

    case (state)
      S_INIT: begin
        if (init_cnt == '0) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (c0_req | c1_req) begin
          grant_en  = 1'b1;
          grant_sel = (c0_req & c1_req) ? ~last_grant : c1_req;
          state_n   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // A completion edge takes priority over a same-cycle timeout.
        if (done_edge) begin
          finish_ok = 1'b1;
          state_n   = S_RESP;
        end else if (tcnt == 8'(TIMEOUT_CYCLES - 1)) begin
          finish_to = 1'b1;
          state_n   = S_RESP;
        end
      end
      S_RESP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_INIT;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      init_cnt    <= INIT_W'(INIT_CYCLES - 1);
      tcnt        <= '0;
      last_grant  <= 1'b1;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      ready       <= 1'b0;
      dv_q        <= 1'b0;
      wc_q        <= 1'b0;
      rdata       <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      state <= state_n;
      dv_q  <= mem_data_valid;
      wc_q  <= mem_write_complete;

      if (state == S_INIT) begin
        if (init_cnt != '0) init_cnt <= init_cnt - 1'b1;
        else                ready    <= 1'b1;
      end

      if (grant_en) begin
        last_grant  <= grant_sel;
        we_q        <= grant_sel ? c1_we    : c0_we;
        mem_address <= grant_sel ? c1_addr  : c0_addr;
        mem_data_in <= grant_sel ? c1_wdata : c0_wdata;
      end

      // The counter value in WAIT equals the number of WAIT cycles already spent.
      if (state == S_ISSUE)     tcnt <= '0;
      else if (state == S_WAIT) tcnt <= tcnt + 1'b1;

      if (finish_ok) begin
        err_q <= 1'b0;
        if (!we_q) rdata <= mem_data_out;
      end else if (finish_to) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_req_read  = (state == S_ISSUE) & ~we_q;
  assign mem_req_write = (state == S_ISSUE) &  we_q;
  assign c0_ack        = (state == S_RESP) & ~last_grant;
  assign c1_ack        = (state == S_RESP) &  last_grant;
  assign c0_err        = c0_ack & err_q;
  assign c1_err        = c1_ack & err_q;

endmodule
